// File: rtl/alarm_pkg.sv
// alarm_pkg: shared encodings for the vehicle alarm controller.
//   - main_state_t : main FSM state codes (also driven onto the display port)
//   - arm_state_t  : arming sub-FSM state codes
//   - prog_sel_t   : delay-register select codes for run-time programming
//   - DELAY_W      : width of every delay / countdown value in seconds
package alarm_pkg;

  localparam int DELAY_W = 4;

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_DISARMED   = 3'd1,
    ST_TRIGGER    = 3'd2,
    ST_ALARM      = 3'd3,
    ST_STOP_ALARM = 3'd4,
    ST_LOCKOUT    = 3'd5
  } main_state_t;

  typedef enum logic [1:0] {
    ARM_WAIT_IGN_OFF    = 2'd0,
    ARM_WAIT_DOOR_OPEN  = 2'd1,
    ARM_WAIT_DOOR_CLOSE = 2'd2,
    ARM_DELAY           = 2'd3
  } arm_state_t;

  typedef enum logic [1:0] {
    SEL_ARM = 2'd0,
    SEL_DRV = 2'd1,
    SEL_PAS = 2'd2,
    SEL_ALM = 2'd3
  } prog_sel_t;

endpackage

// File: rtl/alarm_controller_n_timer.sv
// alarm_timer: one-second tick divider plus a seconds countdown.
// Ports:
//   clock, reset (async, active-low)
//   start      : load load_value into the countdown and realign the divider
//   stop       : abandon the count (countdown -> 0), wins over start
//   load_value : delay in seconds; 0 is treated as 1
//   countdown  : remaining seconds, 0 when idle
//   expired    : one-cycle pulse in the cycle the countdown moves 1 -> 0
//   tick       : one-cycle pulse once every TICK_DIV clocks (free-running)
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int TICK_DIV = 100000000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [DELAY_W-1:0] load_value,
  output logic [DELAY_W-1:0] countdown,
  output logic               expired,
  output logic               tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0]   div_reg;
  logic [DELAY_W-1:0] count_reg;

  assign tick      = (div_reg == DIV_LAST);
  // A restart or stop in the same cycle cancels the pending expiry.
  assign expired   = tick && (count_reg == DELAY_W'(1)) && !start && !stop;
  assign countdown = count_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_reg   <= '0;
      count_reg <= '0;
    end else begin
      if (start || tick) div_reg <= '0;
      else               div_reg <= div_reg + DIV_W'(1);

      if (stop)
        count_reg <= '0;
      else if (start)
        count_reg <= (load_value == '0) ? DELAY_W'(1) : load_value;
      else if (tick && (count_reg != '0))
        count_reg <= count_reg - DELAY_W'(1);
    end
  end

endmodule

// File: rtl/alarm_controller_n.sv
// alarm_controller_n: vehicle alarm supervisor for N_DOORS debounced doors.
// Ports:
//   clock, reset (async, active-low)
//   ignition, doors[N_DOORS]        : debounced inputs, doors[0] = driver door
//   prog_we, prog_sel, prog_value   : delay programming, honoured only when disarmed
//   armed, siren_en, siren_tone     : registered driver outputs
//   state, countdown                : display outputs
//   alarm_zone, retrig_cnt          : trigger diagnostics
module alarm_controller_n
  import alarm_pkg::*;
#(
  parameter int N_DOORS    = 2,
  parameter int TICK_DIV   = 100000000,
  parameter int T_ARM_DEF  = 6,
  parameter int T_DRV_DEF  = 8,
  parameter int T_PAS_DEF  = 15,
  parameter int T_ALM_DEF  = 10,
  parameter int MAX_RETRIG = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ignition,
  input  logic [N_DOORS-1:0] doors,
  input  logic               prog_we,
  input  logic [1:0]         prog_sel,
  input  logic [DELAY_W-1:0] prog_value,
  output logic               armed,
  output logic               siren_en,
  output logic               siren_tone,
  output logic [2:0]         state,
  output logic [DELAY_W-1:0] countdown,
  output logic [N_DOORS-1:0] alarm_zone,
  output logic [1:0]         retrig_cnt
);

  localparam logic [1:0] RETRIG_MAX = 2'(MAX_RETRIG);

  main_state_t        state_reg, state_next;
  arm_state_t         arm_reg, arm_next;
  logic [N_DOORS-1:0] doors_prev_reg;
  logic [N_DOORS-1:0] zone_reg, zone_next;
  logic [1:0]         retrig_reg, retrig_next, retrig_inc;
  logic               armed_reg, siren_en_reg, tone_reg;
  logic               siren_on_next;

  logic               tmr_start, tmr_stop, tmr_expired, tmr_tick;
  logic [DELAY_W-1:0] tmr_value;
  logic [DELAY_W-1:0] delay_val [4];

  logic [N_DOORS-1:0] door_rise;
  logic               any_door;

  assign door_rise = doors & ~doors_prev_reg;
  assign any_door  = |doors;
  assign retrig_inc = (retrig_reg == RETRIG_MAX) ? retrig_reg : retrig_reg + 2'd1;

  // Programmable delay bank, one register per prog_sel code.
  for (genvar gi = 0; gi < 4; gi++) begin : g_delay
    localparam logic [DELAY_W-1:0] DEF =
      (gi == 0) ? DELAY_W'(T_ARM_DEF) :
      (gi == 1) ? DELAY_W'(T_DRV_DEF) :
      (gi == 2) ? DELAY_W'(T_PAS_DEF) : DELAY_W'(T_ALM_DEF);
    logic [DELAY_W-1:0] value_reg;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset)
        value_reg <= DEF;
      else if (prog_we && (state_reg == ST_DISARMED) && (prog_sel == 2'(gi)))
        value_reg <= prog_value;
    end

    assign delay_val[gi] = value_reg;
  end

  alarm_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .start     (tmr_start),
    .stop      (tmr_stop),
    .load_value(tmr_value),
    .countdown (countdown),
    .expired   (tmr_expired),
    .tick      (tmr_tick)
  );

  always_comb begin
    state_next  = state_reg;
    arm_next    = ARM_WAIT_IGN_OFF;
    zone_next   = zone_reg;
    retrig_next = retrig_reg;
    tmr_start   = 1'b0;
    tmr_stop    = 1'b0;
    tmr_value   = delay_val[SEL_ARM];

    if (ignition) begin
      state_next  = ST_DISARMED;
      retrig_next = '0;
      tmr_stop    = 1'b1;
    end else begin
      case (state_reg)
        ST_ARMED: begin
          if (|door_rise) begin
            state_next = ST_TRIGGER;
            zone_next  = doors;
            tmr_start  = 1'b1;
            tmr_value  = doors[0] ? delay_val[SEL_DRV] : delay_val[SEL_PAS];
          end
        end
        ST_DISARMED: begin
          arm_next = arm_reg;
          case (arm_reg)
            ARM_WAIT_IGN_OFF:   arm_next = ARM_WAIT_DOOR_OPEN;
            ARM_WAIT_DOOR_OPEN: if (doors[0]) arm_next = ARM_WAIT_DOOR_CLOSE;
            ARM_WAIT_DOOR_CLOSE: begin
              if (!any_door) begin
                arm_next  = ARM_DELAY;
                tmr_start = 1'b1;
              end
            end
            ARM_DELAY: begin
              if (any_door) begin
                // Abandon the count; it restarts from full on the next close.
                arm_next = ARM_WAIT_DOOR_CLOSE;
                tmr_stop = 1'b1;
              end else if (tmr_expired) begin
                state_next = ST_ARMED;
              end
            end
            default: arm_next = ARM_WAIT_IGN_OFF;
          endcase
        end
        ST_TRIGGER: if (tmr_expired) state_next = ST_ALARM;
        ST_ALARM: begin
          if (!any_door) begin
            state_next = ST_STOP_ALARM;
            tmr_start  = 1'b1;
            tmr_value  = delay_val[SEL_ALM];
          end
        end
        ST_STOP_ALARM: begin
          if (any_door) begin
            retrig_next = retrig_inc;
            tmr_stop    = 1'b1;
            state_next  = (retrig_inc == RETRIG_MAX) ? ST_LOCKOUT : ST_ALARM;
          end else if (tmr_expired) begin
            state_next  = ST_ARMED;
            retrig_next = '0;
            zone_next   = '0;
          end
        end
        ST_LOCKOUT: state_next = ST_LOCKOUT;
        default:    state_next = ST_ARMED;
      endcase
    end

    // The arming sequence only runs while we stay disarmed.
    if (state_next != ST_DISARMED) arm_next = ARM_WAIT_IGN_OFF;
  end

  assign siren_on_next = (state_next == ST_ALARM) || (state_next == ST_LOCKOUT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_ARMED;
      arm_reg        <= ARM_WAIT_IGN_OFF;
      doors_prev_reg <= '0;
      zone_reg       <= '0;
      retrig_reg     <= '0;
      armed_reg      <= 1'b1;
      siren_en_reg   <= 1'b0;
      tone_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      arm_reg        <= arm_next;
      doors_prev_reg <= doors;
      zone_reg       <= zone_next;
      retrig_reg     <= retrig_next;
      armed_reg      <= (state_next == ST_ARMED);
      siren_en_reg   <= siren_on_next;
      if (!siren_on_next) tone_reg <= 1'b0;
      else if (tmr_tick)  tone_reg <= ~tone_reg;
    end
  end

  assign armed      = armed_reg;
  assign siren_en   = siren_en_reg;
  assign siren_tone = tone_reg;
  assign state      = state_reg;
  assign alarm_zone = zone_reg;
  assign retrig_cnt = retrig_reg;

endmodule

// File: tb/tb_alarm_controller_n.sv
module tb_alarm_controller_n;

  logic       clk = 1'b0;
  logic       reset;
  logic       ignition;
  logic [1:0] doors;
  logic       prog_we;
  logic [1:0] prog_sel;
  logic [3:0] prog_value;
  logic       armed, siren_en, siren_tone;
  logic [2:0] state;
  logic [3:0] countdown;
  logic [1:0] alarm_zone, retrig_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alarm_controller_n #(
    .N_DOORS(2), .TICK_DIV(4), .T_ARM_DEF(6), .T_DRV_DEF(8),
    .T_PAS_DEF(15), .T_ALM_DEF(10), .MAX_RETRIG(3)
  ) dut (
    .clock(clk), .reset(reset), .ignition(ignition), .doors(doors),
    .prog_we(prog_we), .prog_sel(prog_sel), .prog_value(prog_value),
    .armed(armed), .siren_en(siren_en), .siren_tone(siren_tone),
    .state(state), .countdown(countdown), .alarm_zone(alarm_zone),
    .retrig_cnt(retrig_cnt)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; ignition = 1'b0; doors = 2'b00;
    prog_we = 1'b0; prog_sel = 2'd0; prog_value = 4'd0;
    step(2);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (armed !== 1'b1) begin failures++; $display("FAIL reset_armed got=%b exp=1", armed); end
    checks++; if (siren_en !== 1'b0 || siren_tone !== 1'b0) begin failures++; $display("FAIL reset_siren got=%b%b exp=00", siren_en, siren_tone); end
    checks++; if (countdown !== 4'd0 || alarm_zone !== 2'b00 || retrig_cnt !== 2'd0) begin failures++; $display("FAIL reset_misc got cd=%0d zone=%b rt=%0d exp 0/00/0", countdown, alarm_zone, retrig_cnt); end
    reset = 1'b1;
    step(1);
    $display("reset: state=%0d armed=%b", state, armed);
  endtask

  task automatic test_trigger_passenger;
    logic tone_a;
    doors = 2'b10;
    step(1);
    checks++; if (state !== 3'd2 || countdown !== 4'd15) begin failures++; $display("FAIL pas_trigger got st=%0d cd=%0d exp 2/15", state, countdown); end
    checks++; if (alarm_zone !== 2'b10 || armed !== 1'b0) begin failures++; $display("FAIL pas_zone got zone=%b armed=%b exp 10/0", alarm_zone, armed); end
    step(59);
    checks++; if (state !== 3'd2 || countdown !== 4'd1 || siren_en !== 1'b0) begin failures++; $display("FAIL pas_last_sec got st=%0d cd=%0d siren=%b exp 2/1/0", state, countdown, siren_en); end
    step(1);
    checks++; if (state !== 3'd3 || siren_en !== 1'b1 || countdown !== 4'd0) begin failures++; $display("FAIL pas_alarm got st=%0d siren=%b cd=%0d exp 3/1/0", state, siren_en, countdown); end
    step(1);
    tone_a = siren_tone;
    step(1);
    checks++; if (siren_tone !== tone_a) begin failures++; $display("FAIL tone_hold got=%b exp=%b", siren_tone, tone_a); end
    step(3);
    checks++; if (siren_tone !== ~tone_a) begin failures++; $display("FAIL tone_toggle got=%b exp=%b", siren_tone, ~tone_a); end
    $display("trigger_passenger: state=%0d siren=%b tone=%b", state, siren_en, siren_tone);
  endtask

  task automatic test_stop_alarm;
    doors = 2'b00;
    step(1);
    checks++; if (state !== 3'd4 || countdown !== 4'd10 || siren_en !== 1'b0) begin failures++; $display("FAIL stop_enter got st=%0d cd=%0d siren=%b exp 4/10/0", state, countdown, siren_en); end
    step(39);
    checks++; if (state !== 3'd4 || countdown !== 4'd1) begin failures++; $display("FAIL stop_last_sec got st=%0d cd=%0d exp 4/1", state, countdown); end
    step(1);
    checks++; if (state !== 3'd0 || armed !== 1'b1 || siren_en !== 1'b0) begin failures++; $display("FAIL stop_rearm got st=%0d armed=%b siren=%b exp 0/1/0", state, armed, siren_en); end
    checks++; if (retrig_cnt !== 2'd0 || alarm_zone !== 2'b00) begin failures++; $display("FAIL stop_clear got rt=%0d zone=%b exp 0/00", retrig_cnt, alarm_zone); end
    $display("stop_alarm: state=%0d armed=%b", state, armed);
  endtask

  task automatic test_simultaneous_and_ignored_prog;
    prog_we = 1'b1; prog_sel = 2'd1; prog_value = 4'd0;
    step(1);
    prog_we = 1'b0;
    doors = 2'b11;
    step(1);
    checks++; if (state !== 3'd2 || countdown !== 4'd8) begin failures++; $display("FAIL both_doors got st=%0d cd=%0d exp 2/8", state, countdown); end
    checks++; if (alarm_zone !== 2'b11) begin failures++; $display("FAIL both_zone got=%b exp=11", alarm_zone); end
    step(32);
    checks++; if (state !== 3'd3) begin failures++; $display("FAIL both_alarm got=%0d exp=3", state); end
    $display("simultaneous: state=%0d zone=%b", state, alarm_zone);
  endtask

  task automatic test_retrigger_lockout;
    doors = 2'b00; step(1);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL rt_stop0 got=%0d exp=4", state); end
    doors = 2'b01; step(1);
    checks++; if (state !== 3'd3 || retrig_cnt !== 2'd1 || countdown !== 4'd0) begin failures++; $display("FAIL rt_1 got st=%0d rt=%0d cd=%0d exp 3/1/0", state, retrig_cnt, countdown); end
    doors = 2'b00; step(1);
    doors = 2'b01; step(1);
    checks++; if (state !== 3'd3 || retrig_cnt !== 2'd2) begin failures++; $display("FAIL rt_2 got st=%0d rt=%0d exp 3/2", state, retrig_cnt); end
    doors = 2'b00; step(1);
    doors = 2'b10; step(1);
    checks++; if (state !== 3'd5 || siren_en !== 1'b1 || retrig_cnt !== 2'd3) begin failures++; $display("FAIL rt_lockout got st=%0d siren=%b rt=%0d exp 5/1/3", state, siren_en, retrig_cnt); end
    doors = 2'b00; step(20);
    checks++; if (state !== 3'd5 || siren_en !== 1'b1) begin failures++; $display("FAIL lockout_hold got st=%0d siren=%b exp 5/1", state, siren_en); end
    ignition = 1'b1; step(1);
    checks++; if (state !== 3'd1 || siren_en !== 1'b0 || retrig_cnt !== 2'd0 || armed !== 1'b0) begin failures++; $display("FAIL lockout_exit got st=%0d siren=%b rt=%0d armed=%b exp 1/0/0/0", state, siren_en, retrig_cnt, armed); end
    $display("retrigger_lockout: state=%0d rt=%0d", state, retrig_cnt);
  endtask

  task automatic test_arming;
    ignition = 1'b0; step(1);
    doors = 2'b01;   step(1);
    doors = 2'b00;   step(1);
    checks++; if (state !== 3'd1 || countdown !== 4'd6) begin failures++; $display("FAIL arm_start got st=%0d cd=%0d exp 1/6", state, countdown); end
    step(12);
    checks++; if (countdown !== 4'd3) begin failures++; $display("FAIL arm_3s got cd=%0d exp=3", countdown); end
    doors = 2'b01; step(1);
    checks++; if (state !== 3'd1 || countdown !== 4'd0) begin failures++; $display("FAIL arm_reopen got st=%0d cd=%0d exp 1/0", state, countdown); end
    doors = 2'b00; step(1);
    checks++; if (countdown !== 4'd6) begin failures++; $display("FAIL arm_restart got cd=%0d exp=6", countdown); end
    step(23);
    checks++; if (state !== 3'd1 || countdown !== 4'd1) begin failures++; $display("FAIL arm_last_sec got st=%0d cd=%0d exp 1/1", state, countdown); end
    step(1);
    checks++; if (state !== 3'd0 || armed !== 1'b1) begin failures++; $display("FAIL arm_done got st=%0d armed=%b exp 0/1", state, armed); end
    $display("arming: state=%0d armed=%b", state, armed);
  endtask

  task automatic test_prog_disarmed;
    ignition = 1'b1; step(1);
    prog_we = 1'b1; prog_sel = 2'd1; prog_value = 4'd0;
    step(1);
    prog_we = 1'b0;
    ignition = 1'b0; step(1);
    doors = 2'b01;   step(1);
    doors = 2'b00;   step(1);
    step(24);
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL prog_rearm got=%0d exp=0", state); end
    doors = 2'b01; step(1);
    checks++; if (state !== 3'd2 || countdown !== 4'd1 || alarm_zone !== 2'b01) begin failures++; $display("FAIL prog_drv1 got st=%0d cd=%0d zone=%b exp 2/1/01", state, countdown, alarm_zone); end
    step(3);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL prog_pre_alarm got=%0d exp=2", state); end
    step(1);
    checks++; if (state !== 3'd3 || siren_en !== 1'b1) begin failures++; $display("FAIL prog_alarm got st=%0d siren=%b exp 3/1", state, siren_en); end
    $display("prog_disarmed: state=%0d cd=%0d", state, countdown);
  endtask

  task automatic test_async_reset;
    #2;
    reset = 1'b0;
    #1;
    checks++; if (armed !== 1'b1 || siren_en !== 1'b0 || siren_tone !== 1'b0) begin failures++; $display("FAIL async_outputs got armed=%b siren=%b tone=%b exp 1/0/0", armed, siren_en, siren_tone); end
    checks++; if (state !== 3'd0 || alarm_zone !== 2'b00 || countdown !== 4'd0) begin failures++; $display("FAIL async_state got st=%0d zone=%b cd=%0d exp 0/00/0", state, alarm_zone, countdown); end
    step(1);
    doors = 2'b00;
    reset = 1'b1;
    step(1);
    $display("async_reset: state=%0d armed=%b", state, armed);
  endtask

  initial begin
    test_reset;
    test_trigger_passenger;
    test_stop_alarm;
    test_simultaneous_and_ignored_prog;
    test_retrigger_lockout;
    test_arming;
    test_prog_disarmed;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
